axil_regfile_slave: RTL and testbench

// - Parametrised AXI4-Lite slave register file; next generation of the fixed 32x32 slave.
// - Independent read/write paths, AW/W accepted in either order, WSTRB byte enables, range-checked decode.
// - Sits behind the AXI4-Lite interconnect as the generic control/status register bank.

---
 rtl/axil_regfile_slave.sv | 160 ++++++++++++++++
 tb/tb_axil_regfile_slave.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_regfile_slave.sv
// axil_regfile_slave: parametrised AXI4-Lite register file with independent read and write paths.
// Define AXIL_REGFILE_DECERR_EN so that out-of-range accesses answer DECERR instead of OKAY.
module axil_regfile_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [ADDR_WIDTH-1:0]   S_AWADDR,
    input  logic                    S_AWVALID,
    output logic                    S_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
    input  logic                    S_WVALID,
    output logic                    S_WREADY,
    output logic [1:0]              S_BRESP,
    output logic                    S_BVALID,
    input  logic                    S_BREADY,
    input  logic [ADDR_WIDTH-1:0]   S_ARADDR,
    input  logic                    S_ARVALID,
    output logic                    S_ARREADY,
    output logic [DATA_WIDTH-1:0]   S_RDATA,
    output logic [1:0]              S_RRESP,
    output logic                    S_RVALID,
    input  logic                    S_RREADY
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int ALSB   = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_WIDTH - ALSB;
    localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W:0] NUM_REGS_C = (IDX_W + 1)'(NUM_REGS);
`ifdef AXIL_REGFILE_DECERR_EN
    localparam logic [1:0] OOR_RESP = 2'b11;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    // W_IDLE | nothing held; W_HAVE_AW / W_HAVE_W | one half held;
    // W_COMMIT | byte-lane write; W_RESP | BVALID until BREADY.  R_IDLE | ARREADY; R_DATA | RVALID.
    typedef enum logic [2:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_COMMIT, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                  awready_q, wready_q, arready_q;
    logic [RIDX_W-1:0]     aw_ridx_q;
    logic                  aw_ok_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;

    logic [IDX_W-1:0] aw_idx, ar_idx;
    logic             aw_in_range, ar_in_range;
    logic             aw_hs, w_hs, ar_hs;
    logic             unused_addr_bits;

    assign aw_idx      = S_AWADDR[ADDR_WIDTH-1:ALSB];
    assign ar_idx      = S_ARADDR[ADDR_WIDTH-1:ALSB];
    assign aw_in_range = ({1'b0, aw_idx} < NUM_REGS_C);
    assign ar_in_range = ({1'b0, ar_idx} < NUM_REGS_C);
    assign unused_addr_bits = ^{S_AWADDR[ALSB-1:0], S_ARADDR[ALSB-1:0]};

    assign aw_hs = S_AWVALID & awready_q;
    assign w_hs  = S_WVALID & wready_q;
    assign ar_hs = S_ARVALID & arready_q;

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) w_next = W_COMMIT;
                else if (aw_hs)    w_next = W_HAVE_AW;
                else if (w_hs)     w_next = W_HAVE_W;
            end
            W_HAVE_AW: if (w_hs) w_next = W_COMMIT;
            W_HAVE_W:  if (aw_hs) w_next = W_COMMIT;
            W_COMMIT:  w_next = W_RESP;
            W_RESP:    if (S_BREADY) w_next = W_IDLE;
            default:   w_next = W_IDLE;
        endcase
    end

    // Ready flags are derived from the next state so they are plain flops at the ports.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_ridx_q <= '0;
            aw_ok_q   <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            w_state   <= w_next;
            awready_q <= (w_next == W_IDLE) || (w_next == W_HAVE_W);
            wready_q  <= (w_next == W_IDLE) || (w_next == W_HAVE_AW);
            if (aw_hs) begin
                aw_ridx_q <= aw_idx[RIDX_W-1:0];
                aw_ok_q   <= aw_in_range;
            end
            if (w_hs) begin
                wdata_q <= S_WDATA;
                wstrb_q <= S_WSTRB;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else if (w_state == W_COMMIT && aw_ok_q) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_q[b]) regs[aw_ridx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (S_RREADY) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read data is captured at the AR handshake, so a same-cycle commit is not visible.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            r_state   <= r_next;
            arready_q <= (r_next == R_IDLE);
            if (ar_hs) begin
                rdata_q <= ar_in_range ? regs[ar_idx[RIDX_W-1:0]] : '0;
                rresp_q <= ar_in_range ? 2'b00 : OOR_RESP;
            end
        end
    end

    assign S_AWREADY = awready_q;
    assign S_WREADY  = wready_q;
    assign S_BVALID  = (w_state == W_RESP);
    assign S_BRESP   = (w_state == W_RESP && !aw_ok_q) ? OOR_RESP : 2'b00;
    assign S_ARREADY = arready_q;
    assign S_RVALID  = (r_state == R_DATA);
    assign S_RDATA   = rdata_q;
    assign S_RRESP   = rresp_q;

endmodule

// File: tb/tb_axil_regfile_slave.sv
// tb_axil_regfile_slave: scoreboard bench for axil_regfile_slave at its default 32x32 configuration.
// Builds with or without AXIL_REGFILE_DECERR_EN; the expected out-of-range response follows the macro.
module tb_axil_regfile_slave;

`ifdef AXIL_REGFILE_DECERR_EN
    localparam logic [1:0] OOR = 2'b11;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] s_awaddr = '0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b0;
    logic [31:0] s_araddr = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready = 1'b0;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    rexp_t       rq[$];
    logic [1:0]  bq[$];
    logic [31:0] model [32];
    int          errors = 0;
    int          checks = 0;

    always #5 aclk = ~aclk;

    axil_regfile_slave dut (
        .ACLK(aclk), .ARESETN(aresetn),
        .S_AWADDR(s_awaddr), .S_AWVALID(s_awvalid), .S_AWREADY(s_awready),
        .S_WDATA(s_wdata), .S_WSTRB(s_wstrb), .S_WVALID(s_wvalid), .S_WREADY(s_wready),
        .S_BRESP(s_bresp), .S_BVALID(s_bvalid), .S_BREADY(s_bready),
        .S_ARADDR(s_araddr), .S_ARVALID(s_arvalid), .S_ARREADY(s_arready),
        .S_RDATA(s_rdata), .S_RRESP(s_rresp), .S_RVALID(s_rvalid), .S_RREADY(s_rready)
    );

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endfunction

    function automatic void model_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
        for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    endfunction

    // AW and W offered together; lat counts edges from the last handshake edge to BVALID seen.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input bit accept, output int lat, output logic [1:0] resp, output bit ok);
        bit aw_done, w_done, aw_hs, w_hs;
        int n;
        ok = 1'b1; aw_done = 1'b0; w_done = 1'b0; n = 0;
        s_awaddr = addr; s_wdata = data; s_wstrb = strb;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            @(posedge aclk); #1;
            if (aw_hs) begin aw_done = 1'b1; s_awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1'b1; s_wvalid = 1'b0; end
            n++;
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        if (!(aw_done && w_done)) ok = 1'b0;
        lat = 1;
        while (ok && !s_bvalid && lat < 20) begin @(posedge aclk); #1; lat++; end
        if (!s_bvalid) ok = 1'b0;
        resp = s_bresp;
        if (accept && ok) begin
            s_bready = 1'b1; @(posedge aclk); #1; s_bready = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                            output bit ok);
        int n;
        ok = 1'b1; n = 0;
        s_araddr = addr; s_arvalid = 1'b1;
        while (!s_arready && n < 20) begin @(posedge aclk); #1; n++; end
        if (!s_arready) ok = 1'b0;
        @(posedge aclk); #1; s_arvalid = 1'b0;
        n = 0;
        while (!s_rvalid && n < 20) begin @(posedge aclk); #1; n++; end
        if (!s_rvalid) ok = 1'b0;
        data = s_rdata; resp = s_rresp;
        s_rready = 1'b1; @(posedge aclk); #1; s_rready = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        checks++; if ({s_awready, s_wready, s_arready} !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b want=000", {s_awready, s_wready, s_arready}); end
        checks++; if ({s_bvalid, s_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_valid got=%b want=00", {s_bvalid, s_rvalid}); end
        checks++; if ({s_rdata, s_rresp, s_bresp} !== 36'h0) begin errors++; $display("FAIL reset_data got rdata=%h rresp=%b bresp=%b want 0", s_rdata, s_rresp, s_bresp); end
        aresetn = 1'b1;
        @(posedge aclk); #1;
        checks++; if ({s_awready, s_wready, s_arready} !== 3'b111) begin errors++; $display("FAIL ready_after_reset got=%b want=111", {s_awready, s_wready, s_arready}); end
    endtask

    task automatic test_basic();
        int lat; logic [1:0] resp, be, r; bit ok; logic [31:0] d; rexp_t e;
        model_write(2, 32'hDEADBEEF, 4'hF);
        bq.push_back(2'b00);
        axi_write(32'h08, 32'hDEADBEEF, 4'hF, 1'b1, lat, resp, ok);
        be = bq.pop_front();
        checks++; if (!ok) begin errors++; $display("FAIL basic_write timeout"); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL basic_latency got=%0d want=2", lat); end
        checks++; if (resp !== be) begin errors++; $display("FAIL basic_bresp got=%b want=%b", resp, be); end
        rq.push_back('{model[2], 2'b00});
        axi_read(32'h08, d, r, ok);
        e = rq.pop_front();
        checks++; if (!ok) begin errors++; $display("FAIL basic_read timeout"); end
        checks++; if (d !== e.data) begin errors++; $display("FAIL basic_rdata got=%h want=%h", d, e.data); end
        checks++; if (r !== e.resp) begin errors++; $display("FAIL basic_rresp got=%b want=%b", r, e.resp); end
        // Low address bits are ignored: 0x0B decodes to the same register as 0x08.
        rq.push_back('{model[2], 2'b00});
        axi_read(32'h0B, d, r, ok);
        e = rq.pop_front();
        checks++; if (d !== e.data || !ok) begin errors++; $display("FAIL unaligned_rdata got=%h want=%h", d, e.data); end
    endtask

    task automatic test_w_first();
        int n; logic [1:0] be, r; bit ok; logic [31:0] d; rexp_t e;
        s_wdata = 32'h11223344; s_wstrb = 4'hF; s_wvalid = 1'b1;
        n = 0;
        while (!s_wready && n < 20) begin @(posedge aclk); #1; n++; end
        @(posedge aclk); #1; s_wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (s_wready !== 1'b0 || s_awready !== 1'b1) begin errors++; $display("FAIL wfirst_hold%0d got wready=%b awready=%b want 0/1", i, s_wready, s_awready); end
            @(posedge aclk); #1;
        end
        model_write(3, 32'h11223344, 4'hF);
        bq.push_back(2'b00);
        s_awaddr = 32'h0C; s_awvalid = 1'b1;
        @(posedge aclk); #1; s_awvalid = 1'b0;
        n = 0;
        while (!s_bvalid && n < 20) begin @(posedge aclk); #1; n++; end
        be = bq.pop_front();
        checks++; if (s_bvalid !== 1'b1 || s_bresp !== be) begin errors++; $display("FAIL wfirst_b got bvalid=%b bresp=%b want 1/%b", s_bvalid, s_bresp, be); end
        checks++; if (s_wready !== 1'b0) begin errors++; $display("FAIL wfirst_wready_in_resp got=%b want=0", s_wready); end
        s_bready = 1'b1; @(posedge aclk); #1; s_bready = 1'b0;
        checks++; if (s_wready !== 1'b1 || s_bvalid !== 1'b0) begin errors++; $display("FAIL wfirst_after_b got wready=%b bvalid=%b want 1/0", s_wready, s_bvalid); end
        rq.push_back('{model[3], 2'b00});
        axi_read(32'h0C, d, r, ok);
        e = rq.pop_front();
        checks++; if (d !== e.data || r !== e.resp || !ok) begin errors++; $display("FAIL wfirst_read got=%h/%b want=%h/%b", d, r, e.data, e.resp); end
    endtask

    task automatic test_strobe();
        int lat; logic [1:0] resp, be, r; bit ok; logic [31:0] d; rexp_t e;
        logic [31:0] wd [3];
        logic [3:0]  ws [3];
        wd[0] = 32'hAAAAAAAA; ws[0] = 4'hF;
        wd[1] = 32'h55555555; ws[1] = 4'b0101;
        wd[2] = 32'hFFFFFFFF; ws[2] = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            model_write(4, wd[k], ws[k]);
            bq.push_back(2'b00);
            axi_write(32'h10, wd[k], ws[k], 1'b1, lat, resp, ok);
            be = bq.pop_front();
            checks++; if (resp !== be || !ok) begin errors++; $display("FAIL strobe_bresp%0d got=%b want=%b", k, resp, be); end
            rq.push_back('{model[4], 2'b00});
            axi_read(32'h10, d, r, ok);
            e = rq.pop_front();
            checks++; if (d !== e.data || r !== e.resp || !ok) begin errors++; $display("FAIL strobe_read%0d got=%h want=%h", k, d, e.data); end
        end
    endtask

    task automatic test_out_of_range();
        int lat; logic [1:0] resp, be, r; bit ok; logic [31:0] d; rexp_t e;
        rq.push_back('{32'h0, OOR});
        axi_read(32'h80, d, r, ok);
        e = rq.pop_front();
        checks++; if (d !== e.data || r !== e.resp || !ok) begin errors++; $display("FAIL oor_read got=%h/%b want=%h/%b", d, r, e.data, e.resp); end
        bq.push_back(OOR);
        axi_write(32'h80, 32'hFFFFFFFF, 4'hF, 1'b1, lat, resp, ok);
        be = bq.pop_front();
        checks++; if (resp !== be || !ok) begin errors++; $display("FAIL oor_bresp got=%b want=%b", resp, be); end
        for (int i = 0; i < 32; i += 31) begin
            rq.push_back('{model[i], 2'b00});
            axi_read(32'(i * 4), d, r, ok);
            e = rq.pop_front();
            checks++; if (d !== e.data || r !== e.resp || !ok) begin errors++; $display("FAIL oor_no_alias%0d got=%h want=%h", i, d, e.data); end
        end
        model_write(31, 32'h13579BDF, 4'hF);
        bq.push_back(2'b00);
        axi_write(32'h7C, 32'h13579BDF, 4'hF, 1'b1, lat, resp, ok);
        be = bq.pop_front();
        checks++; if (resp !== be || !ok) begin errors++; $display("FAIL last_reg_bresp got=%b want=%b", resp, be); end
        rq.push_back('{model[31], 2'b00});
        axi_read(32'h7C, d, r, ok);
        e = rq.pop_front();
        checks++; if (d !== e.data || r !== e.resp || !ok) begin errors++; $display("FAIL last_reg_read got=%h want=%h", d, e.data); end
    endtask

    task automatic test_backpressure();
        int lat, n; logic [1:0] resp, be; bit ok; rexp_t e;
        model_write(5, 32'h12345678, 4'hF);
        bq.push_back(2'b00);
        axi_write(32'h14, 32'h12345678, 4'hF, 1'b0, lat, resp, ok);
        be = bq.pop_front();
        checks++; if (!ok) begin errors++; $display("FAIL bp_write timeout"); end
        s_awaddr = 32'h1C; s_awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge aclk); #1;
            checks++; if (s_bvalid !== 1'b1 || s_bresp !== be || s_awready !== 1'b0) begin errors++; $display("FAIL bp_b_hold%0d got bvalid=%b bresp=%b awready=%b want 1/%b/0", i, s_bvalid, s_bresp, s_awready, be); end
        end
        s_bready = 1'b1; @(posedge aclk); #1; s_bready = 1'b0; s_awvalid = 1'b0;
        checks++; if (s_bvalid !== 1'b0) begin errors++; $display("FAIL bp_b_release got bvalid=%b want=0", s_bvalid); end
        rq.push_back('{model[5], 2'b00});
        s_araddr = 32'h14; s_arvalid = 1'b1;
        n = 0;
        while (!s_arready && n < 20) begin @(posedge aclk); #1; n++; end
        @(posedge aclk); #1;
        s_araddr = 32'h08;
        e = rq.pop_front();
        for (int i = 0; i < 5; i++) begin
            @(posedge aclk); #1;
            checks++; if (s_rvalid !== 1'b1 || s_rdata !== e.data || s_rresp !== e.resp || s_arready !== 1'b0) begin errors++; $display("FAIL bp_r_hold%0d got rvalid=%b rdata=%h arready=%b want 1/%h/0", i, s_rvalid, s_rdata, s_arready, e.data); end
        end
        s_rready = 1'b1; @(posedge aclk); #1; s_rready = 1'b0; s_arvalid = 1'b0;
        checks++; if (s_rvalid !== 1'b0 || s_arready !== 1'b1) begin errors++; $display("FAIL bp_r_release got rvalid=%b arready=%b want 0/1", s_rvalid, s_arready); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [1:0] resp, r; bit ok; logic [31:0] d; rexp_t e;
        model_write(6, 32'hCAFEF00D, 4'hF);
        axi_write(32'h18, 32'hCAFEF00D, 4'hF, 1'b1, lat, resp, ok);
        s_awaddr = 32'h18; s_awvalid = 1'b1;
        s_araddr = 32'h18; s_arvalid = 1'b1;
        @(posedge aclk); #1; s_awvalid = 1'b0; s_arvalid = 1'b0;
        checks++; if (s_awready !== 1'b0 || s_wready !== 1'b1 || s_rvalid !== 1'b1 || s_rdata !== model[6]) begin errors++; $display("FAIL mid_setup got awready=%b wready=%b rvalid=%b rdata=%h want 0/1/1/%h", s_awready, s_wready, s_rvalid, s_rdata, model[6]); end
        s_wdata = 32'h0BADF00D; s_wstrb = 4'hF; s_wvalid = 1'b1;
        #2 aresetn = 1'b0;
        #1;
        checks++; if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b0 || {s_rdata, s_rresp, s_bresp} !== 36'h0) begin errors++; $display("FAIL mid_reset_outputs got rdy=%b%b%b vld=%b%b rdata=%h", s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_rdata); end
        @(posedge aclk); #1; s_wvalid = 1'b0;
        @(posedge aclk); #1; aresetn = 1'b1;
        model_reset();
        @(posedge aclk); #1;
        rq.push_back('{model[6], 2'b00});
        axi_read(32'h18, d, r, ok);
        e = rq.pop_front();
        checks++; if (d !== e.data || r !== e.resp || !ok) begin errors++; $display("FAIL mid_reset_reg got=%h want=%h", d, e.data); end
        checks++; if (rq.size() != 0 || bq.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got r=%0d b=%0d want 0/0", rq.size(), bq.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_w_first();
        test_strobe();
        test_out_of_range();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
